// File: rtl/switch_mmap.sv
// Memory-mapped switch/button input peripheral: a 2-flop synchronizer and a per-bit debounce,
// sticky W1C rise/fall flags and a maskable level interrupt.
module switch_mmap #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    output logic             irq,
    input  logic             re,
    output logic [31:0]      rd,
    input  logic             we,
    input  logic [31:0]      wd,
    input  logic [31:2]      addr
);

    localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] A_STATE = 2'd0;
    localparam logic [1:0] A_RISE  = 2'd1;
    localparam logic [1:0] A_FALL  = 2'd2;
    localparam logic [1:0] A_MASK  = 2'd3;

    logic [WIDTH-1:0] s1, s2;
    logic [WIDTH-1:0] state, state_nxt;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [WIDTH-1:0] rise_flags, fall_flags, irq_mask;
    logic [WIDTH-1:0] rise_set, fall_set, rise_clr, fall_clr;
    logic [1:0]       sel;

    assign sel = addr[3:2];

    always_comb begin
        state_nxt = state;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (s2[i] == state[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                state_nxt[i] = s2[i];
                cnt_nxt[i]   = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CW'(1);
            end
        end
    end

    assign rise_set = state_nxt & ~state;
    assign fall_set = state & ~state_nxt;
    assign rise_clr = (we && sel == A_RISE) ? wd[WIDTH-1:0] : '0;
    assign fall_clr = (we && sel == A_FALL) ? wd[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            state      <= '0;
            rise_flags <= '0;
            fall_flags <= '0;
            irq_mask   <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            s1    <= sw;
            s2    <= s1;
            state <= state_nxt;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
            // a set on the same edge as a clear wins so no event is lost
            rise_flags <= (rise_flags & ~rise_clr) | rise_set;
            fall_flags <= (fall_flags & ~fall_clr) | fall_set;
            if (we && sel == A_MASK) irq_mask <= wd[WIDTH-1:0];
        end
    end

    assign irq = |((rise_flags | fall_flags) & irq_mask);

    always_comb begin
        rd = '0;
        if (re) begin
            unique case (sel)
                A_STATE: rd[WIDTH-1:0] = state;
                A_RISE:  rd[WIDTH-1:0] = rise_flags;
                A_FALL:  rd[WIDTH-1:0] = fall_flags;
                A_MASK:  rd[WIDTH-1:0] = irq_mask;
                default: rd = '0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{addr[31:4], wd};

endmodule

// File: tb/tb_switch_mmap.sv
// Scoreboard bench for switch_mmap with DEBOUNCE_CYCLES=4 and WIDTH=8.
module tb_switch_mmap;

    localparam int unsigned W  = 8;
    localparam int unsigned DC = 4;

    localparam logic [1:0] A_STATE = 2'd0;
    localparam logic [1:0] A_RISE  = 2'd1;
    localparam logic [1:0] A_FALL  = 2'd2;
    localparam logic [1:0] A_MASK  = 2'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  sw;
    logic          irq;
    logic          re, we;
    logic [31:0]   rd, wd;
    logic [31:2]   addr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;

    switch_mmap #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .sw(sw), .irq(irq),
        .re(re), .rd(rd), .we(we), .wd(wd), .addr(addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reads are pushed by the driver and checked here mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (re) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_read", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk(sb_e.tag, rd, sb_e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns before the next posedge without consuming an edge
    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        addr      = '0;
        addr[3:2] = a;
        re        = 1'b1;
        @(negedge clk);
        #1;
        re = 1'b0;
    endtask

    // Consumes exactly one edge: the write takes effect on it
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr      = '0;
        addr[3:2] = a;
        wd        = d;
        we        = 1'b1;
        tick();
        we = 1'b0;
        wd = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        sw    = 8'hFF;
        re    = 1'b0;
        we    = 1'b0;
        wd    = '0;
        addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // debounced state appears on the 6th edge after release (2 sync + 4 stable)
        bus_read(A_STATE, 32'h0, "rst_state_e0");
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus_read(A_STATE, (k < 6) ? 32'h0 : 32'hFF, $sformatf("rst_state_e%0d", k));
        end
        tick(); bus_read(A_RISE, 32'hFF, "rst_rise");
        tick(); bus_read(A_FALL, 32'h00, "rst_fall");
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // return all inputs low and clear every flag
        sw = 8'h00;
        repeat (8) tick();
        bus_read(A_STATE, 32'h00, "low_state");
        tick(); bus_read(A_FALL, 32'hFF, "low_fall");
        tick();
        bus_write(A_FALL, 32'hFF);
        bus_write(A_RISE, 32'hFF);
        bus_read(A_RISE, 32'h00, "clr_rise");
        tick(); bus_read(A_FALL, 32'h00, "clr_fall");
        tick();

        // latency: bit0 set exactly on the 6th edge
        sw = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus_read(A_STATE, (k < 6) ? 32'h0 : 32'h1, $sformatf("lat_state_e%0d", k));
        end
        tick();

        // 3-cycle glitch on bit1 never reaches state
        sw = 8'h03;
        repeat (3) tick();
        sw = 8'h01;
        for (int k = 0; k < 10; k++) begin
            tick();
            bus_read(A_STATE, 32'h01, $sformatf("glitch_state_%0d", k));
        end
        tick(); bus_read(A_RISE, 32'h01, "glitch_rise");
        tick();

        // W1C
        sw = 8'h03;
        repeat (8) tick();
        bus_read(A_RISE, 32'h03, "w1c_pre");
        tick();
        bus_write(A_RISE, 32'h01);
        bus_read(A_RISE, 32'h02, "w1c_bit0");
        tick();
        bus_write(A_RISE, 32'hFFFF_FF00);
        bus_read(A_RISE, 32'h02, "w1c_upper");
        tick();

        // clear of bit2 lands on the same edge state[2] rises: set wins
        sw = 8'h07;
        repeat (5) tick();
        bus_write(A_RISE, 32'h04);
        bus_read(A_RISE, 32'h06, "set_wins");
        tick(); bus_read(A_STATE, 32'h07, "set_wins_state");
        tick();

        // interrupt from a masked-in fall
        bus_write(A_MASK, 32'h04);
        bus_write(A_RISE, 32'hFF);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        sw = 8'h03;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("irq_fall_e%0d", k), {31'd0, irq}, (k < 6) ? 32'd0 : 32'd1);
        end
        bus_read(A_FALL, 32'h04, "irq_fall_flag");
        tick();
        bus_write(A_FALL, 32'h04);
        chk("irq_w1c", {31'd0, irq}, 32'd0);

        // re-trigger, then mask off without clearing
        sw = 8'h07;
        repeat (8) tick();
        sw = 8'h03;
        repeat (8) tick();
        chk("irq_retrig", {31'd0, irq}, 32'd1);
        bus_write(A_MASK, 32'h00);
        chk("irq_masked", {31'd0, irq}, 32'd0);
        bus_read(A_FALL, 32'h04, "masked_fall");
        tick(); bus_read(A_RISE, 32'h04, "masked_rise");
        tick();

        // bus corners
        addr[3:2] = A_MASK;
        #1;
        chk("rd_idle", rd, 32'h0);
        bus_write(A_MASK, 32'h1A5);
        bus_read(A_MASK, 32'h0000_00A5, "mask_rw");
        tick();
        bus_write(A_STATE, 32'hFF);
        bus_read(A_STATE, 32'h03, "state_ro");
        tick();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/switch_mmap.md
Name: switch_mmap

Overview:
- Memory-mapped input peripheral for 8 board switches/buttons: the read-side counterpart of the LED output register.
- Synchronizes and debounces each input bit, latches sticky rising/falling-edge flags, and raises a maskable interrupt.
- Sits on the core's data-memory bus behind the same address decoder as the other mmap peripherals.
- CPU reads state/flags and clears flags by write-1-to-clear.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles required before a debounced bit changes (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sw  input  WIDTH  raw asynchronous switch/button inputs
- irq  output  1  interrupt request, level
- re  input  1  bus read enable
- rd  output  32  bus read data
- we  input  1  bus write enable
- wd  input  32  bus write data
- addr  input  30 ([31:2])  word address; only addr[3:2] decoded

Behaviour:
- Reset (clk edge with reset=1): sync flops, debounced state, per-bit counters, rise_flags, fall_flags and irq_mask all go to 0. irq=0. rd=0 when re=0.
- Synchronizer: two flops per bit, sw -> s1 -> s2, with no reset bypass. s2 lags sw by 2 edges.
- Debounce, per bit i, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - If s2[i]==state[i]: cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: state[i]<=s2[i] and cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - state[i] therefore updates on the DEBOUNCE_CYCLES-th consecutive edge with s2[i]!=state[i].
  - Any glitch back to equality restarts the count.
  - Total sw->state latency is 2+DEBOUNCE_CYCLES edges.
- Edge flags:
  - On the same edge state[i] goes 0->1, rise_flags[i]<=1.
  - On the same edge state[i] goes 1->0, fall_flags[i]<=1.
  - Flags are sticky until cleared.
- Register map (addr[3:2]), unused upper rd bits read 0:
  - 0 STATE: RO, rd={zeros,state}. Writes ignored.
  - 1 RISE: rd={zeros,rise_flags}. Write clears bits where wd[i]=1 (W1C).
  - 2 FALL: rd={zeros,fall_flags}. Write is W1C.
  - 3 MASK: RW, rd={zeros,irq_mask}. Write loads irq_mask<=wd[WIDTH-1:0].
- Read:
  - Combinational, zero wait states: rd valid in the same cycle re=1.
  - Reads have no side effects.
  - rd=0 when re=0.
  - re and we both high: rd shows the pre-write value; the write takes effect on the edge.
- Write: takes effect on the clk edge with we=1. Bits of wd above WIDTH are ignored.
- Simultaneous set and W1C of the same flag bit on one edge: the set wins (flag=1 after the edge). The event is never lost.
- irq=|((rise_flags|fall_flags)&irq_mask), combinational from registers.
  - irq rises the cycle after the flag-setting edge if masked in.
  - irq drops after the clearing edge.
  - Writing MASK=0 drops irq without clearing flags.
- Reset mid-debounce: counters cleared, state=0. The debounce restarts from the current s2 after reset deasserts.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- With DEBOUNCE_CYCLES=1, state follows s2 with 1 edge latency.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=8):
- Reset state: assert reset 2 cycles, sw=8'hFF during reset -> after release, STATE reads 0 until edge 6 after release. Then STATE=0xFF, RISE=0xFF, FALL=0, irq=0 (mask 0).
- Debounce latency/glitch: sw[0] 0->1 held -> STATE bit0 set exactly 6 edges later. A 3-cycle pulse on sw[1] -> STATE bit1 and RISE bit1 never set.
- W1C: after RISE=0x03, write RISE wd=0x01 -> RISE=0x02. Write wd=0xFFFFFF00 -> RISE unchanged 0x02.
- Simultaneous set/clear: time the W1C of bit2 on the same edge state[2] rises -> RISE bit2 reads 1 afterwards.
- Interrupt: MASK=0x04, debounced fall on bit2 -> FALL=0x04, irq=1. Write FALL 0x04 -> irq=0. Re-trigger, then write MASK=0 -> irq=0 with FALL still 0x04.
- Bus: re=0 -> rd=0. re=1, addr[3:2]=3 after MASK write 0x1A5 -> rd=0x000000A5. Write STATE wd=0xFF -> STATE unchanged.
